board_gen_lfsr: RTL and testbench

- Parametrised generator for the Memory Matrix puzzle board.
- Produces an ROWS x COLS tile mask with exactly the requested number of lit tiles, placed pseudo-randomly by a configurable Fibonacci XNOR LFSR.
- Adds to the earlier fixed generator: seedable LFSR, an exact lit-tile count, a start/busy/done handshake, and a guaranteed-termination fallback.
- Sits between the game control FSM, which requests a board per level, and the display/compare logic, which consumes `board`.

---
 rtl/board_gen_lfsr.sv | 149 ++++++++++++++
 tb/tb_board_gen_lfsr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_gen_lfsr.sv
// rtl/board_gen_lfsr.sv - Memory Matrix board generator with an exact lit-tile count.
// A free-running XNOR LFSR picks tile indices; a bounded miss counter forces placement.
module board_gen_lfsr #(
    parameter int                ROWS     = 4,
    parameter int                COLS     = 4,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter int                MAX_MISS = 32,
    localparam int               N        = ROWS * COLS,
    localparam int               IDX_W    = ($clog2(N) < 1) ? 1 : $clog2(N),
    localparam int               CNT_W    = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_lit,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      board,
    output logic [CNT_W-1:0]  lit_count
);

    localparam int                MISS_W    = (MAX_MISS > 1) ? $clog2(MAX_MISS) : 1;
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);
    localparam logic [CNT_W-1:0]  N_C       = CNT_W'(N);
    localparam logic [LFSR_W-1:0] LOCKUP    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLACE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   lfsr_nx;
    logic                fb;
    logic [CNT_W-1:0]    target;
    logic [MISS_W-1:0]   miss;
    logic [IDX_W-1:0]    idx;
    logic                idx_ok;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    place_idx;
    logic                place_en;
    logic                miss_inc;
    logic                accept;

    assign fb  = ~^(lfsr & TAPS);
    assign idx = lfsr[IDX_W-1:0];

    // Only non-power-of-two boards can draw an index past the last tile.
    generate
        if (N == (1 << IDX_W)) begin : g_pow2
            assign idx_ok = 1'b1;
        end else begin : g_npow2
            localparam logic [IDX_W-1:0] N_I = IDX_W'(N);
            assign idx_ok = (idx < N_I);
        end
    endgenerate

    always_comb begin
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!board[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // A seed of all-ones would park the XNOR LFSR forever, so it is mapped to zero.
    always_comb begin
        lfsr_nx = {lfsr[LFSR_W-2:0], fb};
        if (state == S_IDLE && seed_load) begin
            lfsr_nx = (seed == LOCKUP) ? '0 : seed;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        place_en  = 1'b0;
        place_idx = idx;
        miss_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_PLACE;
                end
            end
            S_PLACE: begin
                busy = 1'b1;
                if (lit_count == target) begin
                    state_nx = S_DONE;
                end else if (idx_ok && !board[idx]) begin
                    place_en = 1'b1;
                end else if (miss == MISS_LAST) begin
                    place_en  = 1'b1;
                    place_idx = free_idx;
                end else begin
                    miss_inc = 1'b1;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= '0;
            board     <= '0;
            lit_count <= '0;
            miss      <= '0;
            target    <= '0;
        end else begin
            lfsr <= lfsr_nx;
            if (accept) begin
                target    <= (num_lit > N_C) ? N_C : num_lit;
                board     <= '0;
                lit_count <= '0;
                miss      <= '0;
            end else if (place_en) begin
                board[place_idx] <= 1'b1;
                lit_count        <= lit_count + 1'b1;
                miss             <= '0;
            end else if (miss_inc) begin
                miss <= miss + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_gen_lfsr.sv
// tb/tb_board_gen_lfsr.sv - Randomized model-checked bench for board_gen_lfsr.
// Three instances cover the 4x4 default, a 3x3 board, and a 3x3 board forced onto the fallback.
module tb_board_gen_lfsr;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] seed = '0;
    logic [4:0]  num_lit_a = '0;
    logic [3:0]  num_lit_bc = '0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        seed_load_a = 1'b0, seed_load_b = 1'b0, seed_load_c = 1'b0;

    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] board_a;
    logic [8:0]  board_b, board_c;
    logic [4:0]  lit_a;
    logic [3:0]  lit_b, lit_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cur     = 0;
    int done_cnt [3];

    logic        o_busy, o_done;
    logic [15:0] o_board;
    logic [4:0]  o_lit;

    always #5 clk = ~clk;

    board_gen_lfsr dut_a (
        .clk(clk), .reset(reset), .start(start_a), .num_lit(num_lit_a),
        .seed_load(seed_load_a), .seed(seed), .busy(busy_a), .done(done_a),
        .board(board_a), .lit_count(lit_a)
    );

    board_gen_lfsr #(.ROWS(3), .COLS(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .num_lit(num_lit_bc),
        .seed_load(seed_load_b), .seed(seed), .busy(busy_b), .done(done_b),
        .board(board_b), .lit_count(lit_b)
    );

    board_gen_lfsr #(.ROWS(3), .COLS(3), .TAPS(16'h0001), .MAX_MISS(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .num_lit(num_lit_bc),
        .seed_load(seed_load_c), .seed(seed), .busy(busy_c), .done(done_c),
        .board(board_c), .lit_count(lit_c)
    );

    always_comb begin
        o_busy  = busy_a;
        o_done  = done_a;
        o_board = board_a;
        o_lit   = lit_a;
        case (cur)
            1: begin
                o_busy = busy_b; o_done = done_b;
                o_board = {7'b0, board_b}; o_lit = {1'b0, lit_b};
            end
            2: begin
                o_busy = busy_c; o_done = done_c;
                o_board = {7'b0, board_c}; o_lit = {1'b0, lit_c};
            end
            default: ;
        endcase
    end

    initial begin
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    end

    always @(negedge clk) begin
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
        if (done_c) done_cnt[2]++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sl);
        case (w)
            0: begin start_a = st; seed_load_a = sl; end
            1: begin start_b = st; seed_load_b = sl; end
            default: begin start_c = st; seed_load_c = sl; end
        endcase
    endtask

    // Reference: one LFSR value per PLACE cycle, placement rules applied to a plain bit array.
    task automatic model(input int w, input logic [15:0] sd, input int nl,
                         output logic [15:0] bd, output int cnt, output int lat);
        int          n, mm, target, miss, samples, idx;
        logic [15:0] taps, v;
        bit          fbit;
        n    = (w == 0) ? 16 : 9;
        mm   = (w == 2) ? 2 : 32;
        taps = (w == 2) ? 16'h0001 : 16'hB400;
        target = (nl > n) ? n : nl;
        v = (sd == 16'hFFFF) ? 16'h0000 : sd;
        bd = '0; cnt = 0; miss = 0; samples = 0;
        while (cnt < target) begin
            idx = int'(v) % 16;
            if (idx < n && bd[idx] == 1'b0) begin
                bd[idx] = 1'b1; cnt++; miss = 0;
            end else if (miss == mm - 1) begin
                for (int j = 0; j < n; j++) begin
                    if (bd[j] == 1'b0) begin
                        bd[j] = 1'b1;
                        break;
                    end
                end
                cnt++; miss = 0;
            end else begin
                miss++;
            end
            fbit = ($countones(v & taps) % 2) == 0;
            v = {v[14:0], fbit};
            samples++;
        end
        lat = samples + 2;
    endtask

    task automatic run_check(input int w, input logic [15:0] sd, input int nl,
                             input bit disturb, output logic [15:0] bd_out);
        logic [15:0] exp_bd;
        int          exp_cnt, exp_lat, n, busy_cycles, dc0, mm, target, nmax;
        bit          got;
        model(w, sd, nl, exp_bd, exp_cnt, exp_lat);
        mm     = (w == 2) ? 2 : 32;
        nmax   = (w == 0) ? 16 : 9;
        target = (nl > nmax) ? nmax : nl;
        cur    = w;
        dc0    = done_cnt[w];
        @(negedge clk);
        seed = sd; num_lit_a = 5'(nl); num_lit_bc = 4'(nl);
        drive(w, 1'b1, 1'b1);
        n = 0; got = 0; busy_cycles = 0;
        while (!got && n < 700) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(w, 1'b0, 1'b0);
            if (disturb && n == 3) begin
                seed = 16'h5A5A; num_lit_a = 5'd1; num_lit_bc = 4'd1;
                drive(w, 1'b1, 1'b1);
            end
            if (disturb && n == 4) drive(w, 1'b0, 1'b0);
            if (o_busy) busy_cycles++;
            check_eq("popcount_inv", $countones(o_board), 32'(o_lit));
            if (o_done) got = 1;
        end
        check_eq("done_seen", 32'(got), 32'd1);
        check_eq("latency", n, exp_lat);
        check_eq("latency_bound", 32'(n <= target * mm + 2), 32'd1);
        check_eq("busy_cycles", busy_cycles, exp_lat - 1);
        check_eq("board", o_board, exp_bd);
        check_eq("lit_count", 32'(o_lit), exp_cnt);
        bd_out = o_board;
        @(negedge clk);
        check_eq("done_single", {30'b0, o_done, o_busy}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("board_hold", o_board, exp_bd);
        check_eq("done_count", done_cnt[w] - dc0, 32'd1);
    endtask

    initial begin
        logic [15:0] bd1, bd2;
        int          w, nl;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_board_a", board_a, 16'h0);
        check_eq("rst_lit_a", 32'(lit_a), 32'd0);
        check_eq("rst_busy", {29'b0, busy_a, busy_b, busy_c}, 32'd0);
        check_eq("rst_board_bc", {board_b, board_c}, 32'd0);
        check_eq("idle_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 32'd0);

        // Zero target
        run_check(0, 16'h1234, 0, 1'b0, bd1);
        check_eq("zero_board", bd1, 16'h0000);

        // Full board and clamping
        run_check(0, 16'h1234, 16, 1'b0, bd1);
        check_eq("full_board", bd1, 16'hFFFF);
        run_check(0, 16'hBEEF, 20, 1'b0, bd1);
        check_eq("clamp_board", bd1, 16'hFFFF);

        // 3x3 repeatability
        run_check(1, 16'h00A5, 5, 1'b0, bd1);
        run_check(1, 16'h00A5, 5, 1'b0, bd2);
        check_eq("repeat_board", bd2, bd1);
        check_eq("repeat_popcount", $countones(bd1), 32'd5);

        // Lock-up seed mapped to zero
        @(negedge clk);
        seed = 16'hFFFF; seed_load_a = 1'b1;
        @(posedge clk);
        #1;
        check_eq("lockup_seed", dut_a.lfsr, 16'h0000);
        @(negedge clk);
        seed_load_a = 1'b0;

        // Start and seed_load pulses mid-PLACE are ignored
        run_check(0, 16'hC0DE, 16, 1'b1, bd1);
        run_check(0, 16'h0F0F, 10, 1'b1, bd1);

        // Fallback placement
        run_check(2, 16'h0000, 9, 1'b0, bd1);
        check_eq("fallback_board", bd1, 16'h01FF);
        run_check(2, 16'h3C3C, 6, 1'b0, bd1);

        // Randomized runs
        for (int it = 0; it < 24; it++) begin
            w  = int'($urandom_range(0, 2));
            nl = (w == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 12));
            run_check(w, (it % 8 == 7) ? 16'hFFFF : 16'($urandom), nl, 1'b0, bd1);
        end

        // Asynchronous reset mid-generation aborts
        cur = 0;
        @(negedge clk);
        seed = 16'h1234; num_lit_a = 5'd16; start_a = 1'b1; seed_load_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; seed_load_a = 1'b0;
        repeat (5) @(negedge clk);
        w = done_cnt[0];
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_board", board_a, 16'h0);
        check_eq("async_lit", 32'(lit_a), 32'd0);
        check_eq("async_flags", {30'b0, busy_a, done_a}, 32'd0);
        check_eq("async_lfsr", dut_a.lfsr, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("abort_no_done", done_cnt[0] - w, 32'd0);
        check_eq("abort_idle", {31'b0, busy_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
